debug_unit: RTL and testbench

- Host-side control block sitting directly upstream of the 5-stage pipeline top.
- Receives a UART byte stream, loads instruction memory, and drives the pipeline's valid/reset in run or single-step mode.
- Consumes the pipeline halt flag and reports the executed cycle count back over the UART transmitter.

---
 rtl/debug_unit.sv | 235 +++++++++++++++++++++++
 tb/tb_debug_unit.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_unit.sv
// UART debug controller: loads instruction memory, runs or single-steps the pipeline, reports the cycle count.
// Imem write lands the cycle after a word's 4th byte; each tx byte waits for i_tx_done. Option: DEBUG_LOAD_CHECKSUM_EN.
module debug_unit #(
    parameter int NB_REG             = 32,
    parameter int NB_INSTR           = 32,
    parameter int N_ADDR             = 2048,
    parameter int LOG2_N_INSMEM_ADDR = 11,
    parameter int NB_BYTE            = 8,
    parameter int NB_LEN             = 16
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic [NB_BYTE-1:0]            i_rx_data,
    input  logic                          i_rx_valid,
    output logic [NB_BYTE-1:0]            o_tx_data,
    output logic                          o_tx_start,
    input  logic                          i_tx_done,
    output logic                          o_imem_we,
    output logic [LOG2_N_INSMEM_ADDR-1:0] o_imem_addr,
    output logic [NB_INSTR-1:0]           o_imem_data,
    output logic                          o_pipe_valid,
    output logic                          o_pipe_reset,
    input  logic                          i_halt,
    output logic [NB_REG-1:0]             o_cycle_count,
    output logic                          o_busy
);

`ifdef DEBUG_LOAD_CHECKSUM_EN
    typedef enum logic [3:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_LOAD, S_RUN, S_STEP, S_SEND, S_CHK, S_ACK
    } state_t;
    localparam state_t S_LOAD_END = S_CHK;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_LOAD, S_RUN, S_STEP, S_SEND
    } state_t;
    localparam state_t S_LOAD_END = S_IDLE;
`endif

    localparam logic [NB_LEN-1:0] ADDR_LIM = NB_LEN'(N_ADDR);

    state_t                          state_q, state_d;
    logic [NB_LEN-1:0]               len_q, len_d;
    logic [NB_LEN-1:0]               words_q, words_d;
    logic [LOG2_N_INSMEM_ADDR-1:0]   addr_q, addr_d;
    logic [NB_INSTR-1:0]             word_q, word_d;
    logic [1:0]                      bidx_q, bidx_d;
    logic                            we_q, we_d;
    logic                            done_q, done_d;
    logic [NB_REG-1:0]               cnt_q, cnt_d;
    logic [NB_REG-1:0]               snap_q, snap_d;
    logic [NB_BYTE-1:0]              tx_data_q, tx_data_d;
    logic                            tx_start_q, tx_start_d;
    logic [1:0]                      tx_idx_q, tx_idx_d;
    logic                            sup_q, sup_d;
    logic                            pipe_rst_q, pipe_rst_d;
    logic                            pipe_valid;
`ifdef DEBUG_LOAD_CHECKSUM_EN
    logic [NB_BYTE-1:0]              csum_q, csum_d;
`endif

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        words_d    = words_q;
        addr_d     = addr_q;
        word_d     = word_q;
        bidx_d     = bidx_q;
        we_d       = 1'b0;
        done_d     = 1'b0;
        cnt_d      = cnt_q;
        snap_d     = snap_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        tx_idx_d   = tx_idx_q;
        sup_d      = sup_q;
        pipe_valid = 1'b0;
`ifdef DEBUG_LOAD_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        // Address advances after each write pulse and parks at the top word.
        if (we_q && addr_q != '1) addr_d = addr_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (i_rx_valid) begin
                    case (i_rx_data)
                        8'h01: begin
                            state_d = S_LEN_LO;
                            cnt_d   = '0;
                            addr_d  = '0;
                            words_d = '0;
                            bidx_d  = '0;
`ifdef DEBUG_LOAD_CHECKSUM_EN
                            csum_d  = '0;
`endif
                        end
                        8'h02: state_d = S_RUN;
                        8'h03: begin
                            state_d = S_STEP;
                            sup_d   = i_halt;
                        end
                        8'h04: begin
                            state_d    = S_SEND;
                            snap_d     = cnt_q;
                            tx_data_d  = cnt_q[NB_BYTE-1:0];
                            tx_start_d = 1'b1;
                            tx_idx_d   = '0;
                        end
                        default: ;
                    endcase
                end
            end
            S_LEN_LO: begin
                if (i_rx_valid) begin
                    len_d   = {len_q[NB_LEN-1:NB_BYTE], i_rx_data};
                    state_d = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (i_rx_valid) begin
                    len_d   = {i_rx_data, len_q[NB_BYTE-1:0]};
                    state_d = (len_d == '0) ? S_LOAD_END : S_LOAD;
                end
            end
            S_LOAD: begin
                // done_q marks the write cycle; bytes arriving in the final one are not data.
                if (done_q && words_q == len_q) begin
                    state_d = S_LOAD_END;
                end else if (i_rx_valid) begin
                    word_d = {i_rx_data, word_q[NB_INSTR-1:NB_BYTE]};
                    bidx_d = bidx_q + 2'd1;
`ifdef DEBUG_LOAD_CHECKSUM_EN
                    csum_d = csum_q ^ i_rx_data;
`endif
                    if (bidx_q == 2'd3) begin
                        done_d  = 1'b1;
                        we_d    = (words_q < ADDR_LIM);
                        words_d = words_q + 1'b1;
                    end
                end
            end
`ifdef DEBUG_LOAD_CHECKSUM_EN
            S_CHK: begin
                if (i_rx_valid) begin
                    tx_data_d  = (csum_q == i_rx_data) ? 8'hAA : 8'hEE;
                    tx_start_d = 1'b1;
                    state_d    = S_ACK;
                end
            end
            S_ACK: begin
                if (!tx_start_q && i_tx_done) state_d = S_IDLE;
            end
`endif
            S_RUN: begin
                if (i_halt) state_d = S_IDLE;
                else        pipe_valid = 1'b1;
            end
            S_STEP: begin
                pipe_valid = !i_halt && !sup_q;
                state_d    = S_IDLE;
            end
            S_SEND: begin
                if (!tx_start_q && i_tx_done) begin
                    if (tx_idx_q == 2'd3) begin
                        state_d = S_IDLE;
                    end else begin
                        tx_idx_d   = tx_idx_q + 2'd1;
                        snap_d     = snap_q >> NB_BYTE;
                        tx_data_d  = snap_q[2*NB_BYTE-1:NB_BYTE];
                        tx_start_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (pipe_valid && cnt_q != '1) cnt_d = cnt_q + 1'b1;
        pipe_rst_d = (state_d == S_IDLE) || (state_d == S_RUN) ||
                     (state_d == S_STEP) || (state_d == S_SEND);
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            words_q    <= '0;
            addr_q     <= '0;
            word_q     <= '0;
            bidx_q     <= '0;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
            snap_q     <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            tx_idx_q   <= '0;
            sup_q      <= 1'b0;
            pipe_rst_q <= 1'b0;
`ifdef DEBUG_LOAD_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            words_q    <= words_d;
            addr_q     <= addr_d;
            word_q     <= word_d;
            bidx_q     <= bidx_d;
            we_q       <= we_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
            snap_q     <= snap_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            tx_idx_q   <= tx_idx_d;
            sup_q      <= sup_d;
            pipe_rst_q <= pipe_rst_d;
`ifdef DEBUG_LOAD_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign o_tx_data     = tx_data_q;
    assign o_tx_start    = tx_start_q;
    assign o_imem_we     = we_q;
    assign o_imem_addr   = addr_q;
    assign o_imem_data   = word_q;
    assign o_pipe_valid  = pipe_valid;
    assign o_pipe_reset  = pipe_rst_q;
    assign o_cycle_count = cnt_q;
    assign o_busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_debug_unit.sv
// Bench for debug_unit: directed command sequence with random data, gaps and tx delays against a behavioural model.
module tb_debug_unit;
    localparam int N_ADDR = 2048;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic        tx_done;
    logic        o_imem_we;
    logic [10:0] o_imem_addr;
    logic [31:0] o_imem_data;
    logic        o_pipe_valid;
    logic        o_pipe_reset;
    logic        halt;
    logic [31:0] o_cycle_count;
    logic        o_busy;

    always #5 clk = ~clk;

    debug_unit dut (
        .i_clock      (clk),
        .i_reset      (rst_n),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .o_tx_data    (o_tx_data),
        .o_tx_start   (o_tx_start),
        .i_tx_done    (tx_done),
        .o_imem_we    (o_imem_we),
        .o_imem_addr  (o_imem_addr),
        .o_imem_data  (o_imem_data),
        .o_pipe_valid (o_pipe_valid),
        .o_pipe_reset (o_pipe_reset),
        .i_halt       (halt),
        .o_cycle_count(o_cycle_count),
        .o_busy       (o_busy)
    );

    int          checks = 0;
    int          errors = 0;
    int          vcnt = 0;
    int          tx_viol = 0;
    int          bad_rst = 0;
    bit          tx_busy = 1'b0;
    logic [10:0] wr_a [$];
    logic [31:0] wr_d [$];
    logic [7:0]  tx_q [$];
    logic [31:0] ld_words [0:2049];
    logic [31:0] exp_count;

    // Observed-activity recorder, sampled mid-cycle.
    always @(negedge clk) begin
        if (o_imem_we) begin
            wr_a.push_back(o_imem_addr);
            wr_d.push_back(o_imem_data);
            if (o_pipe_reset) bad_rst++;
        end
        if (o_pipe_valid) vcnt++;
        if (tx_done) tx_busy = 1'b0;
        if (o_tx_start) begin
            tx_q.push_back(o_tx_data);
            if (tx_busy) tx_viol++;
            tx_busy = 1'b1;
        end
    end

    // UART transmitter stand-in: done arrives 1..4 cycles after each start.
    initial begin
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (o_tx_start) begin
                repeat ($urandom_range(4, 1)) @(posedge clk);
                #1 tx_done = 1'b1;
                @(posedge clk);
                #1 tx_done = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no end of run, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic put(input logic [7:0] b, input int gap);
        cmd(b);
        repeat (gap) tick();
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k;
        k = 0;
        while (o_busy && k < budget) begin
            tick();
            k++;
        end
        check({tag, "_timeout"}, 64'(o_busy), 64'(0));
        repeat (2) tick();
    endtask

    task automatic do_load(input int n, input int gap, input bit bad_ck);
        logic [7:0] ck;
        int ne, nbad;
        ck = 8'h00;
        bad_rst = 0;
        wr_a.delete();
        wr_d.delete();
        tx_q.delete();
        put(8'h01, gap);
        put(n[7:0], gap);
        put(n[15:8], gap);
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 4; b++) begin
                logic [7:0] by;
                by = ld_words[i][8*b +: 8];
                ck = ck ^ by;
                put(by, gap);
            end
        end
`ifdef DEBUG_LOAD_CHECKSUM_EN
        put(bad_ck ? (ck ^ 8'h01) : ck, gap);
        wait_idle(100, "load");
        check("load_ack_count", 64'(tx_q.size()), 64'(1));
        if (tx_q.size() == 1)
            check("load_ack_byte", 64'(tx_q[0]), bad_ck ? 64'(8'hEE) : 64'(8'hAA));
`else
        if (bad_ck) $display("checksum byte %02h not sent in this build", ck);
        wait_idle(100, "load");
        check("load_no_tx", 64'(tx_q.size()), 64'(0));
`endif
        exp_count = 32'd0;
        ne = (n < N_ADDR) ? n : N_ADDR;
        check("load_write_count", 64'(wr_a.size()), 64'(ne));
        nbad = 0;
        for (int i = 0; i < wr_a.size(); i++)
            if (wr_a[i] !== 11'(i) || wr_d[i] !== ld_words[i]) nbad++;
        check("load_write_content", 64'(nbad), 64'(0));
        check("load_pipe_reset_during_write", 64'(bad_rst), 64'(0));
        check("load_pipe_reset_after", 64'(o_pipe_reset), 64'(1));
        check("load_count_cleared", 64'(o_cycle_count), 64'(exp_count));
    endtask

    task automatic do_run(input int k, input bit inject);
        int v0, t;
        v0 = vcnt;
        t = 0;
        cmd(8'h02);
        if (inject) begin
            rx_data  = 8'h01;
            rx_valid = 1'b1;
            tick();
            rx_valid = 1'b0;
            t++;
        end
        while ((vcnt - v0) < k && t < 500) begin
            tick();
            t++;
        end
        halt = 1'b1;
        repeat (3) tick();
        exp_count = exp_count + 32'(k);
        check("run_valid_cycles", 64'(vcnt - v0), 64'(k));
        check("run_count", 64'(o_cycle_count), 64'(exp_count));
        check("run_back_idle", 64'(o_busy), 64'(0));
        check("run_pipe_reset", 64'(o_pipe_reset), 64'(1));
        halt = 1'b0;
        tick();
    endtask

    task automatic do_step(input bit h_cmd, input bit h_step, input int exp_v);
        int v0;
        v0 = vcnt;
        halt = h_cmd;
        cmd(8'h03);
        halt = h_step;
        tick();
        halt = 1'b0;
        repeat (2) tick();
        exp_count = exp_count + 32'(exp_v);
        check("step_valid_cycles", 64'(vcnt - v0), 64'(exp_v));
        check("step_count", 64'(o_cycle_count), 64'(exp_count));
        check("step_back_idle", 64'(o_busy), 64'(0));
    endtask

    task automatic do_send(input bit inject);
        int v0, viol0;
        v0 = vcnt;
        viol0 = tx_viol;
        tx_q.delete();
        cmd(8'h04);
        if (inject) begin
            tick();
            cmd(8'h02);
        end
        wait_idle(200, "send");
        check("send_nbytes", 64'(tx_q.size()), 64'(4));
        for (int i = 0; i < 4; i++)
            if (i < tx_q.size())
                check($sformatf("send_byte%0d", i), 64'(tx_q[i]), 64'(exp_count[8*i +: 8]));
        check("send_handshake", 64'(tx_viol - viol0), 64'(0));
        check("send_no_valid", 64'(vcnt - v0), 64'(0));
        check("send_count_kept", 64'(o_cycle_count), 64'(exp_count));
    endtask

    initial begin
        int v0, n;
        rst_n     = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        halt      = 1'b0;
        exp_count = 32'd0;
        repeat (3) tick();
        check("rst_pipe_reset", 64'(o_pipe_reset), 64'(0));
        check("rst_busy", 64'(o_busy), 64'(0));
        check("rst_we", 64'(o_imem_we), 64'(0));
        check("rst_addr", 64'(o_imem_addr), 64'(0));
        check("rst_data", 64'(o_imem_data), 64'(0));
        check("rst_tx_start", 64'(o_tx_start), 64'(0));
        check("rst_tx_data", 64'(o_tx_data), 64'(0));
        check("rst_pipe_valid", 64'(o_pipe_valid), 64'(0));
        check("rst_count", 64'(o_cycle_count), 64'(0));
        rst_n = 1'b1;
        tick();
        check("post_rst_pipe_reset", 64'(o_pipe_reset), 64'(1));

        ld_words[0] = 32'h12345678;
        ld_words[1] = 32'hDEADBEEF;
        do_load(2, 2, 1'b0);
        do_run(7, 1'b0);
        do_send(1'b0);

        n = $urandom_range(6, 3);
        for (int i = 0; i < n; i++) ld_words[i] = $urandom;
        do_load(n, $urandom_range(3, 1), 1'b0);
        do_run($urandom_range(25, 2), 1'b1);
        do_run($urandom_range(300, 200), 1'b0);
        do_send(1'b1);

        do_load(0, 1, 1'b0);
        put(8'h55, 2);
        check("junk_byte_ignored", 64'(o_busy), 64'(0));
        do_step(1'b0, 1'b0, 1);
        do_step(1'b0, 1'b0, 1);
        do_step(1'b0, 1'b0, 1);
        do_step(1'b1, 1'b1, 0);
        do_step(1'b1, 1'b0, 0);
        do_step(1'b0, 1'b1, 0);

        v0 = vcnt;
        halt = 1'b1;
        cmd(8'h02);
        repeat (3) tick();
        halt = 1'b0;
        check("run_halted_entry_valid", 64'(vcnt - v0), 64'(0));
        check("run_halted_entry_idle", 64'(o_busy), 64'(0));
        do_send(1'b0);

        wr_a.delete();
        put(8'h01, 1);
        put(8'h02, 1);
        put(8'h00, 1);
        put(8'hAA, 1);
        put(8'hBB, 1);
        check("midload_busy", 64'(o_busy), 64'(1));
        check("midload_pipe_reset", 64'(o_pipe_reset), 64'(0));
        rst_n = 1'b0;
        tick();
        check("abort_busy", 64'(o_busy), 64'(0));
        check("abort_pipe_reset", 64'(o_pipe_reset), 64'(0));
        check("abort_we", 64'(o_imem_we), 64'(0));
        check("abort_count", 64'(o_cycle_count), 64'(0));
        rst_n = 1'b1;
        repeat (2) tick();
        put(8'hCC, 1);
        put(8'hDD, 1);
        check("abort_no_write", 64'(wr_a.size()), 64'(0));
        check("abort_idle", 64'(o_busy), 64'(0));
        exp_count = 32'd0;
        do_step(1'b0, 1'b0, 1);

        for (int i = 0; i < 2050; i++) ld_words[i] = $urandom;
        do_load(2050, 1, 1'b0);
        if (wr_a.size() > 0)
            check("capacity_last_addr", 64'(wr_a[$]), 64'(N_ADDR - 1));

`ifdef DEBUG_LOAD_CHECKSUM_EN
        ld_words[0] = 32'h04030201;
        do_load(1, 1, 1'b0);
        do_load(1, 1, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
